// File: rtl/debug_scan_bridge.sv
// rtl/debug_scan_bridge.sv - virtual-JTAG scan bridge folded into the system clock domain
`timescale 1ns/1ps
module debug_scan_bridge #(
    parameter int DR_W        = 38,
    parameter int IR_W        = 2,
    parameter int NCH         = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  vs_tck,
    input  logic                  vs_tdi,
    input  logic                  vs_cdr,
    input  logic                  vs_sdr,
    input  logic                  vs_udr,
    input  logic                  vs_uir,
    input  logic [IR_W-1:0]       ir_in,
    input  logic [NCH*DR_W-1:0]   capture_data,
    output logic                  tdo,
    output logic [1:0]            ir_out,
    output logic [DR_W-1:0]       jdo,
    output logic [IR_W-1:0]       ir_cur,
    output logic [NCH-1:0]        take_action,
    output logic [NCH-1:0]        take_no_action
);

    localparam int CNT_W = $clog2(DR_W + 2);
    localparam int VS_W  = 6;
    localparam int B_TCK = 0;
    localparam int B_TDI = 1;
    localparam int B_CDR = 2;
    localparam int B_SDR = 3;
    localparam int B_UDR = 4;
    localparam int B_UIR = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_SHIFT,
        ST_UPDATE
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [VS_W-1:0]                   w_vs_raw;
    logic [SYNC_STAGES-1:0][VS_W-1:0]  r_vs_sync;
    logic [SYNC_STAGES-1:0][IR_W-1:0]  r_ir_sync;
    logic [VS_W-1:0]                   w_vs_s;
    logic [VS_W-1:0]                   r_vs_d;
    logic [IR_W-1:0]                   r_ir_d;
    logic                              r_tck_rise;
    logic                              r_udr_rise;
    logic                              r_uir_rise;

    logic [DR_W-1:0]   r_sr;
    logic [CNT_W-1:0]  r_shift_cnt;
    logic              r_overrun;
    logic [DR_W-1:0]   r_jdo;
    logic [IR_W-1:0]   r_ir_cur;
    logic [NCH-1:0]    r_take_act;
    logic [NCH-1:0]    r_take_nact;
    logic              r_tdo;

    logic [DR_W-1:0]   w_cap_word;
    logic              w_capture;
    logic              w_shift;

    assign w_vs_raw = {vs_uir, vs_udr, vs_sdr, vs_cdr, vs_tdi, vs_tck};
    assign w_vs_s   = r_vs_sync[SYNC_STAGES-1];

    // Edge pulses are registered so that r_vs_d carries the level inputs aligned with them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vs_sync  <= '0;
            r_ir_sync  <= '0;
            r_vs_d     <= '0;
            r_ir_d     <= '0;
            r_tck_rise <= 1'b0;
            r_udr_rise <= 1'b0;
            r_uir_rise <= 1'b0;
        end else begin
            r_vs_sync[0] <= w_vs_raw;
            r_ir_sync[0] <= ir_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_vs_sync[i] <= r_vs_sync[i-1];
                r_ir_sync[i] <= r_ir_sync[i-1];
            end
            r_vs_d     <= w_vs_s;
            r_ir_d     <= r_ir_sync[SYNC_STAGES-1];
            r_tck_rise <= w_vs_s[B_TCK] & ~r_vs_d[B_TCK];
            r_udr_rise <= w_vs_s[B_UDR] & ~r_vs_d[B_UDR];
            r_uir_rise <= w_vs_s[B_UIR] & ~r_vs_d[B_UIR];
        end
    end

    always_comb begin
        w_cap_word = '0;
        for (int k = 0; k < NCH; k++) begin
            if (r_ir_cur == IR_W'(k)) begin
                w_cap_word = capture_data[k*DR_W +: DR_W];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Capture beats shift when cdr and sdr are both seen on one TCK rise.
    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        w_shift      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_tck_rise && r_vs_d[B_CDR]) begin
                    w_capture    = 1'b1;
                    w_next_state = ST_CAPTURE;
                end
            end
            ST_CAPTURE, ST_SHIFT: begin
                if (r_tck_rise && r_vs_d[B_CDR]) begin
                    w_capture    = 1'b1;
                    w_next_state = ST_CAPTURE;
                end else if (r_udr_rise) begin
                    w_next_state = ST_UPDATE;
                end else if (r_tck_rise && r_vs_d[B_SDR]) begin
                    w_shift      = 1'b1;
                    w_next_state = ST_SHIFT;
                end
            end
            ST_UPDATE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sr        <= '0;
            r_shift_cnt <= '0;
            r_overrun   <= 1'b0;
            r_jdo       <= '0;
            r_ir_cur    <= '0;
            r_take_act  <= '0;
            r_take_nact <= '0;
            r_tdo       <= 1'b0;
        end else begin
            r_tdo       <= r_sr[0];
            r_take_act  <= '0;
            r_take_nact <= '0;
            if (w_capture) begin
                r_sr        <= w_cap_word;
                r_shift_cnt <= '0;
                r_overrun   <= 1'b0;
            end else if (w_shift) begin
                r_sr <= {r_vs_d[B_TDI], r_sr[DR_W-1:1]};
                if (r_shift_cnt >= CNT_W'(DR_W)) begin
                    r_overrun <= 1'b1;
                end
                if (r_shift_cnt != CNT_W'(DR_W + 1)) begin
                    r_shift_cnt <= r_shift_cnt + CNT_W'(1);
                end
            end
            // Pulse is decoded from the pre-update ir_cur even if uir lands in the same cycle.
            if (r_state == ST_UPDATE) begin
                r_jdo <= r_sr;
                for (int k = 0; k < NCH; k++) begin
                    if (r_ir_cur == IR_W'(k)) begin
                        if (r_sr[DR_W-1]) begin
                            r_take_act[k] <= 1'b1;
                        end else begin
                            r_take_nact[k] <= 1'b1;
                        end
                    end
                end
            end
            if (r_uir_rise) begin
                r_ir_cur <= r_ir_d;
            end
        end
    end

    assign tdo            = r_tdo;
    assign ir_out         = {r_overrun, (r_state != ST_IDLE)};
    assign jdo            = r_jdo;
    assign ir_cur         = r_ir_cur;
    assign take_action    = r_take_act;
    assign take_no_action = r_take_nact;

endmodule
